crtram_arbiter: RTL and testbench

Sequencer and arbiter for the three-plane (B/R/G) 16 KiB CRT video RAM. It shares the single 14-bit VRAM address bus between two requesters:

- **Display fetch:** a pulse request that reads all three planes at one address and latches the pixel bytes.
- **Sub-CPU:** a single-plane request/acknowledge read or write.

It drives the CRT RAM's address, write-enable, plane-select and write-data pins. It sits between the CRTC/sub-CPU bus and the CRT RAM.

---
 rtl/crtram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_crtram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtram_arbiter.sv
// crtram_arbiter: shares the 14-bit CRT VRAM address bus between the display
// fetch (three-plane read at one address) and the sub-CPU (single-plane
// read/write). Every access holds the bus for two cycles (address, latch),
// and the latch cycle arbitrates for the following access so that accesses
// can run back to back. All outputs are registered.
//
// CPU handshake: CPUREQ acts as "valid" and CPUACK as the one-cycle "ready"
// completion strobe. CPUREQ and its qualifiers (CPUWR, CPUPLANE, CPUADRS,
// CPUDIN) stay stable from assertion until the cycle in which CPUACK is high;
// the request is retired by that strobe, and CPUREQ is not granted again
// while CPUACK is high, so one request yields exactly one access.
module crtram_arbiter (
  input  logic        CLKSYS,
  input  logic        RSTn,
  input  logic        DISPREQ,
  input  logic [13:0] DISPADRS,
  output logic [7:0]  PIXB,
  output logic [7:0]  PIXR,
  output logic [7:0]  PIXG,
  output logic        PIXVLD,
  output logic        DISPOVR,
  input  logic        DISPOVRCLR,
  input  logic        CPUREQ,
  input  logic        CPUWR,
  input  logic [1:0]  CPUPLANE,
  input  logic [13:0] CPUADRS,
  input  logic [7:0]  CPUDIN,
  output logic [7:0]  CPUDOUT,
  output logic        CPUACK,
  output logic [13:0] SVRADRS,
  output logic        SVWEn,
  output logic        SDRAMBn,
  output logic        SDRAMRn,
  output logic        SDRAMGn,
  output logic [7:0]  SDATABUS,
  input  logic [7:0]  CRTRAMDATA,
  input  logic [7:0]  SVDATAB,
  input  logic [7:0]  SVDATAR,
  input  logic [7:0]  SVDATAG,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DADR = 3'd1,
    ST_DLAT = 3'd2,
    ST_CADR = 3'd3,
    ST_CLAT = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        pend, pend_nxt;
  logic [13:0] pend_adrs, pend_adrs_nxt;
  logic        ovr_nxt;

  logic        disp_want;
  logic [13:0] disp_adrs;
  logic        cpu_want;
  logic        arb_slot;
  logic        enter_dadr;

  logic [2:0]  plane_sel_n;   // {G, R, B}, active-low
  logic [2:0]  sel_n_nxt;
  logic        we_n_nxt;
  logic [13:0] adrs_nxt;
  logic [7:0]  data_nxt;
  logic [7:0]  dout_nxt;

  assign dbg_state = state;

  // Arbitration inputs: a live DISPREQ carries the newest address and wins
  // over an older pending one; the CPU is never re-granted out of CLAT
  // because its request is still held until the ACK that follows.
  always_comb begin
    disp_want = DISPREQ | pend;
    disp_adrs = DISPREQ ? DISPADRS : pend_adrs;
    arb_slot  = (state == ST_IDLE) || (state == ST_DLAT) || (state == ST_CLAT);
    cpu_want  = CPUREQ && !CPUACK && (state != ST_CLAT);
  end

  // State register
  always_ff @(posedge CLKSYS or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: display first, then CPU, from any arbitration slot
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DLAT, ST_CLAT: begin
        if (disp_want)     state_nxt = ST_DADR;
        else if (cpu_want) state_nxt = ST_CADR;
        else               state_nxt = ST_IDLE;
      end
      ST_DADR: state_nxt = ST_DLAT;
      ST_CADR: state_nxt = ST_CLAT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending display request and overrun bookkeeping
  always_comb begin
    enter_dadr    = arb_slot && (state_nxt == ST_DADR);
    pend_nxt      = pend;
    pend_adrs_nxt = pend_adrs;
    ovr_nxt       = DISPOVR;
    if (DISPREQ && (state != ST_IDLE)) begin
      pend_nxt      = 1'b1;
      pend_adrs_nxt = DISPADRS;
    end
    if (enter_dadr) pend_nxt = 1'b0;
    if (DISPOVRCLR) ovr_nxt = 1'b0;
    if (DISPREQ && (state != ST_IDLE) && pend) ovr_nxt = 1'b1;
  end

  // Pending flag, pending address and overrun flag registers
  always_ff @(posedge CLKSYS or negedge RSTn) begin
    if (!RSTn) begin
      pend      <= 1'b0;
      pend_adrs <= 14'd0;
      DISPOVR   <= 1'b0;
    end else begin
      pend      <= pend_nxt;
      pend_adrs <= pend_adrs_nxt;
      DISPOVR   <= ovr_nxt;
    end
  end

  // Output next-values, derived from the state being entered or left
  always_comb begin
    case (CPUPLANE)
      2'd0:    plane_sel_n = 3'b110;
      2'd1:    plane_sel_n = 3'b101;
      2'd2:    plane_sel_n = 3'b011;
      default: plane_sel_n = 3'b111;
    endcase

    sel_n_nxt = 3'b111;
    if ((state_nxt == ST_CADR) || (state_nxt == ST_CLAT)) sel_n_nxt = plane_sel_n;

    we_n_nxt = !((state_nxt == ST_CADR) && CPUWR && (CPUPLANE != 2'd3));

    adrs_nxt = SVRADRS;
    if (enter_dadr)                  adrs_nxt = disp_adrs;
    else if (state_nxt == ST_CADR)   adrs_nxt = CPUADRS;

    data_nxt = SDATABUS;
    if (state_nxt == ST_CADR) data_nxt = CPUDIN;

    dout_nxt = CPUDOUT;
    if (state == ST_CLAT) dout_nxt = (CPUWR || (CPUPLANE == 2'd3)) ? 8'h00 : CRTRAMDATA;
  end

  // VRAM pin registers; SVWEn and selects go inactive asynchronously on reset
  always_ff @(posedge CLKSYS or negedge RSTn) begin
    if (!RSTn) begin
      SVRADRS  <= 14'd0;
      SDATABUS <= 8'd0;
      SVWEn    <= 1'b1;
      SDRAMBn  <= 1'b1;
      SDRAMRn  <= 1'b1;
      SDRAMGn  <= 1'b1;
    end else begin
      SVRADRS  <= adrs_nxt;
      SDATABUS <= data_nxt;
      SVWEn    <= we_n_nxt;
      SDRAMBn  <= sel_n_nxt[0];
      SDRAMRn  <= sel_n_nxt[1];
      SDRAMGn  <= sel_n_nxt[2];
    end
  end

  // Requester-side result registers: pixel bytes, CPU read data and strobes
  always_ff @(posedge CLKSYS or negedge RSTn) begin
    if (!RSTn) begin
      PIXB    <= 8'd0;
      PIXR    <= 8'd0;
      PIXG    <= 8'd0;
      PIXVLD  <= 1'b0;
      CPUDOUT <= 8'd0;
      CPUACK  <= 1'b0;
    end else begin
      if (state == ST_DLAT) begin
        PIXB <= SVDATAB;
        PIXR <= SVDATAR;
        PIXG <= SVDATAG;
      end
      PIXVLD  <= (state == ST_DLAT);
      CPUDOUT <= dout_nxt;
      CPUACK  <= (state == ST_CLAT);
    end
  end

endmodule

// File: tb/tb_crtram_arbiter.sv
// tb_crtram_arbiter: directed bench for crtram_arbiter with a behavioural
// three-plane synchronous VRAM attached to the DUT pins.
module tb_crtram_arbiter;

  logic        CLKSYS;
  logic        RSTn;
  logic        DISPREQ;
  logic [13:0] DISPADRS;
  logic [7:0]  PIXB, PIXR, PIXG;
  logic        PIXVLD;
  logic        DISPOVR;
  logic        DISPOVRCLR;
  logic        CPUREQ;
  logic        CPUWR;
  logic [1:0]  CPUPLANE;
  logic [13:0] CPUADRS;
  logic [7:0]  CPUDIN;
  logic [7:0]  CPUDOUT;
  logic        CPUACK;
  logic [13:0] SVRADRS;
  logic        SVWEn;
  logic        SDRAMBn, SDRAMRn, SDRAMGn;
  logic [7:0]  SDATABUS;
  logic [7:0]  CRTRAMDATA;
  logic [7:0]  SVDATAB, SVDATAR, SVDATAG;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int p3_sel_bad = 0;
  logic [7:0] exp_q[$];

  crtram_arbiter dut (
    .CLKSYS(CLKSYS), .RSTn(RSTn),
    .DISPREQ(DISPREQ), .DISPADRS(DISPADRS),
    .PIXB(PIXB), .PIXR(PIXR), .PIXG(PIXG), .PIXVLD(PIXVLD),
    .DISPOVR(DISPOVR), .DISPOVRCLR(DISPOVRCLR),
    .CPUREQ(CPUREQ), .CPUWR(CPUWR), .CPUPLANE(CPUPLANE),
    .CPUADRS(CPUADRS), .CPUDIN(CPUDIN), .CPUDOUT(CPUDOUT), .CPUACK(CPUACK),
    .SVRADRS(SVRADRS), .SVWEn(SVWEn),
    .SDRAMBn(SDRAMBn), .SDRAMRn(SDRAMRn), .SDRAMGn(SDRAMGn),
    .SDATABUS(SDATABUS), .CRTRAMDATA(CRTRAMDATA),
    .SVDATAB(SVDATAB), .SVDATAR(SVDATAR), .SVDATAG(SVDATAG),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLKSYS = 1'b0;
  always #5 CLKSYS = ~CLKSYS;

  // ---------------- VRAM model ----------------
  logic [7:0]  mem_b [0:16383];
  logic [7:0]  mem_r [0:16383];
  logic [7:0]  mem_g [0:16383];
  logic [7:0]  q_b, q_r, q_g;
  logic        bd_we;
  logic [1:0]  bd_plane;
  logic [13:0] bd_adrs;
  logic [7:0]  bd_data;

  always @(posedge CLKSYS) begin
    if (bd_we) begin
      case (bd_plane)
        2'd0: mem_b[bd_adrs] <= bd_data;
        2'd1: mem_r[bd_adrs] <= bd_data;
        default: mem_g[bd_adrs] <= bd_data;
      endcase
    end else if (!SVWEn) begin
      if (!SDRAMBn) mem_b[SVRADRS] <= SDATABUS;
      if (!SDRAMRn) mem_r[SVRADRS] <= SDATABUS;
      if (!SDRAMGn) mem_g[SVRADRS] <= SDATABUS;
    end
    q_b <= mem_b[SVRADRS];
    q_r <= mem_r[SVRADRS];
    q_g <= mem_g[SVRADRS];
  end

  assign SVDATAB = q_b;
  assign SVDATAR = q_r;
  assign SVDATAG = q_g;

  always_comb begin
    case ({SDRAMGn, SDRAMRn, SDRAMBn})
      3'b110:  CRTRAMDATA = q_b;
      3'b101:  CRTRAMDATA = q_r;
      3'b011:  CRTRAMDATA = q_g;
      default: CRTRAMDATA = 8'hEE;
    endcase
  end

  // A plane-3 request must never pull any select low
  always @(negedge CLKSYS) begin
    if (RSTn && CPUREQ && (CPUPLANE == 2'd3) && ({SDRAMGn, SDRAMRn, SDRAMBn} != 3'b111))
      p3_sel_bad++;
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [1:0] plane, input logic [13:0] adrs, input logic [7:0] data);
    @(negedge CLKSYS);
    bd_we = 1'b1; bd_plane = plane; bd_adrs = adrs; bd_data = data;
    @(negedge CLKSYS);
    bd_we = 1'b0;
  endtask

  task automatic cpu_access(input logic wr, input logic [1:0] plane, input logic [13:0] adrs,
                            input logic [7:0] din, output logic [7:0] dout, output logic ok);
    @(negedge CLKSYS);
    CPUREQ = 1'b1; CPUWR = wr; CPUPLANE = plane; CPUADRS = adrs; CPUDIN = din;
    ok = 1'b0;
    dout = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLKSYS);
      if (CPUACK) begin
        dout = CPUDOUT;
        ok = 1'b1;
        break;
      end
    end
    CPUREQ = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  plane;
    logic [13:0] adrs;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
  } cpu_vec_t;

  cpu_vec_t vecs[13];

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] dout;
    logic       ok;
    logic [7:0] got;
    int         vld_cnt;

    vecs[0]  = '{1'b0, 2'd1, 14'h3FFF, 8'h00, 8'hA5};
    vecs[1]  = '{1'b0, 2'd0, 14'h3FFF, 8'h00, 8'h5A};
    vecs[2]  = '{1'b0, 2'd2, 14'h3FFF, 8'h00, 8'h3C};
    vecs[3]  = '{1'b1, 2'd3, 14'h0123, 8'hFF, 8'h00};
    vecs[4]  = '{1'b0, 2'd0, 14'h0123, 8'h00, 8'h11};
    vecs[5]  = '{1'b0, 2'd1, 14'h0123, 8'h00, 8'h22};
    vecs[6]  = '{1'b0, 2'd2, 14'h0123, 8'h00, 8'h33};
    vecs[7]  = '{1'b0, 2'd3, 14'h0123, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 2'd2, 14'h0000, 8'hC3, 8'h00};
    vecs[9]  = '{1'b0, 2'd2, 14'h0000, 8'h00, 8'hC3};
    vecs[10] = '{1'b1, 2'd0, 14'h0000, 8'h0F, 8'h00};
    vecs[11] = '{1'b0, 2'd0, 14'h0000, 8'h00, 8'h0F};
    vecs[12] = '{1'b0, 2'd2, 14'h0000, 8'h00, 8'hC3};

    RSTn = 1'b0; DISPREQ = 1'b0; DISPADRS = '0; DISPOVRCLR = 1'b0;
    CPUREQ = 1'b0; CPUWR = 1'b0; CPUPLANE = '0; CPUADRS = '0; CPUDIN = '0;
    bd_we = 1'b0; bd_plane = '0; bd_adrs = '0; bd_data = '0;

    // Reset values
    repeat (3) @(negedge CLKSYS);
    RSTn = 1'b1;
    @(negedge CLKSYS);
    chk("rst_svradrs", {18'd0, SVRADRS}, 32'd0);
    chk("rst_sdatabus", {24'd0, SDATABUS}, 32'd0);
    chk("rst_svwen", {31'd0, SVWEn}, 32'd1);
    chk("rst_sel", {29'd0, SDRAMGn, SDRAMRn, SDRAMBn}, 32'h7);
    chk("rst_pix", {8'd0, PIXB, PIXR, PIXG}, 32'd0);
    chk("rst_strobes", {28'd0, PIXVLD, CPUACK, DISPOVR, 1'b0}, 32'd0);
    chk("rst_cpudout", {24'd0, CPUDOUT}, 32'd0);

    // Preload
    poke(2'd0, 14'h0123, 8'h11);
    poke(2'd1, 14'h0123, 8'h22);
    poke(2'd2, 14'h0123, 8'h33);
    poke(2'd0, 14'h3FFF, 8'h5A);
    poke(2'd1, 14'h3FFF, 8'h00);
    poke(2'd2, 14'h3FFF, 8'h3C);
    poke(2'd0, 14'h0000, 8'h00);
    poke(2'd1, 14'h0000, 8'h00);
    poke(2'd2, 14'h0000, 8'h00);
    poke(2'd0, 14'h0010, 8'hA1);
    poke(2'd0, 14'h0020, 8'hA2);
    poke(2'd0, 14'h0030, 8'hA3);
    poke(2'd0, 14'h0200, 8'h01);

    // Display fetch: PIXVLD after edge 2
    @(negedge CLKSYS);
    DISPREQ = 1'b1; DISPADRS = 14'h0123;
    @(negedge CLKSYS);
    DISPREQ = 1'b0;
    chk("disp_adrs", {18'd0, SVRADRS}, 32'h0123);
    chk("disp_sel", {28'd0, SVWEn, SDRAMGn, SDRAMRn, SDRAMBn}, 32'hF);
    chk("disp_vld_e0", {31'd0, PIXVLD}, 32'd0);
    @(negedge CLKSYS);
    chk("disp_vld_e1", {31'd0, PIXVLD}, 32'd0);
    @(negedge CLKSYS);
    chk("disp_vld_e2", {31'd0, PIXVLD}, 32'd1);
    chk("disp_pix", {8'd0, PIXB, PIXR, PIXG}, 32'h112233);
    @(negedge CLKSYS);
    chk("disp_vld_e3", {31'd0, PIXVLD}, 32'd0);

    // CPU write R plane, cycle by cycle
    CPUREQ = 1'b1; CPUWR = 1'b1; CPUPLANE = 2'd1; CPUADRS = 14'h3FFF; CPUDIN = 8'hA5;
    @(negedge CLKSYS);
    chk("wr_e0_pins", {28'd0, SVWEn, SDRAMGn, SDRAMRn, SDRAMBn}, 32'h5);
    chk("wr_e0_adrs", {18'd0, SVRADRS}, 32'h3FFF);
    chk("wr_e0_data", {24'd0, SDATABUS}, 32'hA5);
    @(negedge CLKSYS);
    chk("wr_e1_pins", {28'd0, SVWEn, SDRAMGn, SDRAMRn, SDRAMBn}, 32'hD);
    chk("wr_e1_ack", {31'd0, CPUACK}, 32'd0);
    @(negedge CLKSYS);
    chk("wr_e2_ack", {31'd0, CPUACK}, 32'd1);
    chk("wr_e2_pins", {28'd0, SVWEn, SDRAMGn, SDRAMRn, SDRAMBn}, 32'hF);
    CPUREQ = 1'b0;
    @(negedge CLKSYS);
    chk("wr_e3_ack", {31'd0, CPUACK}, 32'd0);
    chk("wr_mem_r", {24'd0, mem_r[14'h3FFF]}, 32'hA5);
    chk("wr_mem_b", {24'd0, mem_b[14'h3FFF]}, 32'h5A);
    chk("wr_mem_g", {24'd0, mem_g[14'h3FFF]}, 32'h3C);

    // Table-driven CPU accesses with a scoreboard of expected read data
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_dout);
      cpu_access(vecs[i].wr, vecs[i].plane, vecs[i].adrs, vecs[i].din, dout, ok);
      got = exp_q.pop_front();
      if (!ok) chk($sformatf("vec%0d_ack_timeout", i), 32'd0, 32'd1);
      else     chk($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, got});
    end
    chk("p3_no_select", p3_sel_bad, 32'd0);
    chk("p3_mem", {8'd0, mem_b[14'h0123], mem_r[14'h0123], mem_g[14'h0123]}, 32'h112233);

    // Collision: display first, CPU granted at edge 2, ACK after edge 4
    @(negedge CLKSYS);
    CPUREQ = 1'b1; CPUWR = 1'b0; CPUPLANE = 2'd0; CPUADRS = 14'h0123; CPUDIN = 8'h00;
    DISPREQ = 1'b1; DISPADRS = 14'h0123;
    @(negedge CLKSYS);
    DISPREQ = 1'b0;
    chk("col_e0_sel", {29'd0, SDRAMGn, SDRAMRn, SDRAMBn}, 32'h7);
    @(negedge CLKSYS);
    @(negedge CLKSYS);
    chk("col_e2_vld", {31'd0, PIXVLD}, 32'd1);
    chk("col_e2_cadr", {17'd0, SDRAMBn, SVRADRS}, {17'd0, 1'b0, 14'h0123});
    chk("col_e2_ack", {31'd0, CPUACK}, 32'd0);
    @(negedge CLKSYS);
    chk("col_e3_ack", {31'd0, CPUACK}, 32'd0);
    @(negedge CLKSYS);
    chk("col_e4_ack", {31'd0, CPUACK}, 32'd1);
    chk("col_e4_dout", {24'd0, CPUDOUT}, 32'h11);
    CPUREQ = 1'b0;
    @(negedge CLKSYS);
    chk("col_e5_ack", {31'd0, CPUACK}, 32'd0);

    // Overrun: requests at edges 0,1,2; fetches for 0x10 and 0x30 only
    DISPREQ = 1'b1; DISPADRS = 14'h0010;
    @(negedge CLKSYS);
    DISPADRS = 14'h0020;
    @(negedge CLKSYS);
    chk("ovr_e1_flag", {31'd0, DISPOVR}, 32'd0);
    DISPADRS = 14'h0030;
    @(negedge CLKSYS);
    DISPREQ = 1'b0;
    chk("ovr_e2_flag", {31'd0, DISPOVR}, 32'd1);
    chk("ovr_e2_pix", {23'd0, PIXVLD, PIXB}, {23'd0, 1'b1, 8'hA1});
    @(negedge CLKSYS);
    chk("ovr_e3_vld", {31'd0, PIXVLD}, 32'd0);
    @(negedge CLKSYS);
    chk("ovr_e4_pix", {23'd0, PIXVLD, PIXB}, {23'd0, 1'b1, 8'hA3});
    vld_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLKSYS);
      if (PIXVLD) vld_cnt++;
    end
    chk("ovr_no_extra_fetch", vld_cnt, 32'd0);
    DISPOVRCLR = 1'b1;
    @(negedge CLKSYS);
    DISPOVRCLR = 1'b0;
    chk("ovr_clr", {31'd0, DISPOVR}, 32'd0);

    // Reset asserted while a write is being driven
    CPUREQ = 1'b1; CPUWR = 1'b1; CPUPLANE = 2'd0; CPUADRS = 14'h0200; CPUDIN = 8'h77;
    @(negedge CLKSYS);
    chk("rstw_we_low", {31'd0, SVWEn}, 32'd0);
    #1 RSTn = 1'b0;
    #1;
    chk("rstw_async_pins", {28'd0, SVWEn, SDRAMGn, SDRAMRn, SDRAMBn}, 32'hF);
    @(negedge CLKSYS);
    CPUREQ = 1'b0;
    RSTn = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLKSYS);
      if (CPUACK) vld_cnt++;
    end
    chk("rstw_no_ack", vld_cnt, 32'd0);
    chk("rstw_mem", {24'd0, mem_b[14'h0200]}, 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
